// File: rtl/decode_issue_unit.sv
// rtl/decode_issue_unit.sv - decodes a fetch bundle and issues it in hazard-free program-order groups
module decode_issue_unit #(
    parameter int NUM_SLOTS = 2,
    parameter int MEM_PORTS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SLOTS-1:0]      in_slot_valid,
    input  logic [32*NUM_SLOTS-1:0]   in_instr,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NUM_SLOTS-1:0]      out_slot_valid,
    output logic [32*NUM_SLOTS-1:0]   out_instr,
    output logic [16*NUM_SLOTS-1:0]   out_ctrl,
    output logic [NUM_SLOTS-1:0]      out_illegal
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    // Bit positions inside a 16-bit control word.
    localparam int C_BRANCH = 13;
    localparam int C_BRNE   = 12;
    localparam int C_MRD    = 11;
    localparam int C_MWR    = 8;
    localparam int C_RWR    = 7;
    localparam int C_ASRC   = 6;
    localparam int C_JUMP   = 5;
    localparam int C_PCSRC  = 4;

    function automatic logic [16:0] decode_op(input logic [5:0] op, input logic [5:0] fn);
        logic [15:0] c;
        logic        ill;
        c   = '0;
        ill = 1'b0;
        case (op)
            6'h00: begin
                c[15:14] = 2'b01;
                c[C_RWR] = 1'b1;
                case (fn)
                    6'h20: c[3:0] = 4'b0000;
                    6'h22: c[3:0] = 4'b0001;
                    6'h24: c[3:0] = 4'b0010;
                    6'h25: c[3:0] = 4'b0011;
                    6'h2A: c[3:0] = 4'b0100;
                    6'h14: c[3:0] = 4'b0101;
                    6'h27: c[3:0] = 4'b0110;
                    6'h15: c[3:0] = 4'b0111;
                    6'h00: c[3:0] = 4'b1000;
                    6'h02: c[3:0] = 4'b1001;
                    6'h08: begin
                        c[C_PCSRC] = 1'b1;
                        c[C_RWR]   = 1'b0;
                    end
                    default: begin
                        ill      = 1'b1;
                        c[C_RWR] = 1'b0;
                    end
                endcase
            end
            6'h08, 6'h0C, 6'h0D, 6'h16, 6'h0A: begin
                c[C_ASRC] = 1'b1;
                c[C_RWR]  = 1'b1;
                case (op)
                    6'h0C:   c[3:0] = 4'b0010;
                    6'h0D:   c[3:0] = 4'b0011;
                    6'h16:   c[3:0] = 4'b0111;
                    6'h0A:   c[3:0] = 4'b0100;
                    default: c[3:0] = 4'b0000;
                endcase
            end
            6'h23: begin
                c[C_MRD]  = 1'b1;
                c[10:9]   = 2'b01;
                c[C_ASRC] = 1'b1;
                c[C_RWR]  = 1'b1;
            end
            6'h2B: begin
                c[C_MWR]  = 1'b1;
                c[C_ASRC] = 1'b1;
            end
            6'h04, 6'h05: begin
                c[C_BRANCH] = 1'b1;
                c[C_BRNE]   = (op == 6'h05);
                c[3:0]      = 4'b0001;
            end
            6'h02: begin
                c[C_JUMP]  = 1'b1;
                c[C_PCSRC] = 1'b1;
            end
            6'h03: begin
                c[C_JUMP]  = 1'b1;
                c[C_PCSRC] = 1'b1;
                c[C_RWR]   = 1'b1;
                c[15:14]   = 2'b10;
                c[10:9]    = 2'b10;
            end
            default: ill = 1'b1;
        endcase
        return {ill, c};
    endfunction

    logic [0:0]                state;
    logic                      rdy_en;
    logic [NUM_SLOTS-1:0]      pending;
    logic [32*NUM_SLOTS-1:0]   held_instr;

    logic [16*NUM_SLOTS-1:0]   dec_ctrl;
    logic [NUM_SLOTS-1:0]      dec_ill;
    logic [NUM_SLOTS-1:0]      dec_wr;
    logic [NUM_SLOTS-1:0]      dec_rdrt;
    logic [NUM_SLOTS-1:0]      dec_mem;
    logic [NUM_SLOTS-1:0]      dec_cf;
    logic [4:0]                dec_rs  [NUM_SLOTS];
    logic [4:0]                dec_rt  [NUM_SLOTS];
    logic [4:0]                dec_dst [NUM_SLOTS];

    logic [NUM_SLOTS-1:0]      group;
    logic [NUM_SLOTS-1:0]      remaining;
    logic [16*NUM_SLOTS-1:0]   grp_ctrl;
    logic                      out_free;
    logic                      load;
    logic                      accept;

    always_comb begin : decode_comb
        logic [16:0] d;
        logic [5:0]  op;
        d        = '0;
        op       = '0;
        dec_ctrl = '0;
        dec_ill  = '0;
        dec_wr   = '0;
        dec_rdrt = '0;
        dec_mem  = '0;
        dec_cf   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            op                 = held_instr[32*i+26 +: 6];
            d                  = decode_op(op, held_instr[32*i +: 6]);
            dec_ctrl[16*i +: 16] = d[15:0];
            dec_ill[i]         = d[16];
            dec_rs[i]          = held_instr[32*i+21 +: 5];
            dec_rt[i]          = held_instr[32*i+16 +: 5];
            case (d[15:14])
                2'b01:   dec_dst[i] = held_instr[32*i+11 +: 5];
                2'b10:   dec_dst[i] = 5'd31;
                default: dec_dst[i] = dec_rt[i];
            endcase
            // $0 is hardwired, so writing it never creates a dependency.
            dec_wr[i]   = d[C_RWR] && (dec_dst[i] != 5'd0);
            dec_rdrt[i] = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
            dec_mem[i]  = d[C_MRD] | d[C_MWR];
            dec_cf[i]   = d[C_BRANCH] | d[C_JUMP] | d[C_PCSRC];
        end
    end

    // Grow the group over pending slots in program order; the first hazard closes it.
    always_comb begin : group_comb
        logic [31:0] wmask;
        int          mem_cnt;
        logic        closed;
        logic        cf_seen;
        logic        hazard;
        wmask   = '0;
        mem_cnt = 0;
        closed  = 1'b0;
        cf_seen = 1'b0;
        hazard  = 1'b0;
        group   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (pending[i] && !closed) begin
                hazard = cf_seen
                      || wmask[dec_rs[i]]
                      || (dec_rdrt[i] && wmask[dec_rt[i]])
                      || (dec_wr[i] && wmask[dec_dst[i]])
                      || (dec_mem[i] && (mem_cnt >= MEM_PORTS));
                if (hazard) begin
                    closed = 1'b1;
                end else begin
                    group[i] = 1'b1;
                    if (dec_wr[i]) wmask[dec_dst[i]] = 1'b1;
                    if (dec_mem[i]) mem_cnt = mem_cnt + 1;
                    if (dec_cf[i]) cf_seen = 1'b1;
                end
            end
        end
    end

    always_comb begin
        grp_ctrl = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            grp_ctrl[16*i +: 16] = group[i] ? dec_ctrl[16*i +: 16] : 16'h0000;
        end
    end

    assign remaining = pending & ~group;
    assign out_free  = !out_valid || out_ready;
    assign load      = (state == ISSUE) && out_free && !flush;
    assign in_ready  = rdy_en && !flush
                    && ((state == IDLE) || (out_free && (remaining == '0)));
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            rdy_en         <= 1'b0;
            pending        <= '0;
            held_instr     <= '0;
            out_valid      <= 1'b0;
            out_slot_valid <= '0;
            out_instr      <= '0;
            out_ctrl       <= '0;
            out_illegal    <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (flush) begin
                state          <= IDLE;
                pending        <= '0;
                out_valid      <= 1'b0;
                out_slot_valid <= '0;
                out_ctrl       <= '0;
                out_illegal    <= '0;
            end else begin
                if (load) begin
                    out_valid      <= 1'b1;
                    out_slot_valid <= group;
                    out_instr      <= held_instr;
                    out_ctrl       <= grp_ctrl;
                    out_illegal    <= dec_ill & group;
                end else if (out_ready) begin
                    out_valid <= 1'b0;
                end
                // A new bundle may land in the same edge that issues the last group of the old one.
                if (accept) begin
                    held_instr <= in_instr;
                    pending    <= in_slot_valid;
                    state      <= (|in_slot_valid) ? ISSUE : IDLE;
                end else if (load) begin
                    pending <= remaining;
                    state   <= (|remaining) ? ISSUE : IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_unit.sv
// tb/tb_decode_issue_unit.sv - self-checking bench for decode_issue_unit
module tb_decode_issue_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, flush;
    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0]   a_in_sv, a_out_sv, a_out_ill;
    logic [63:0]  a_in_instr, a_out_instr;
    logic [31:0]  a_out_ctrl;
    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0]   b_in_sv, b_out_sv, b_out_ill;
    logic [127:0] b_in_instr, b_out_instr;
    logic [63:0]  b_out_ctrl;

    int vectors = 0;
    int miscompares = 0;

    logic [3:0]   q_sv[$];
    logic [3:0]   q_ill[$];
    logic [63:0]  q_ctrl[$];
    logic [127:0] q_instr[$];

    decode_issue_unit #(.NUM_SLOTS(2), .MEM_PORTS(1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_slot_valid(a_in_sv), .in_instr(a_in_instr),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_slot_valid(a_out_sv),
        .out_instr(a_out_instr), .out_ctrl(a_out_ctrl), .out_illegal(a_out_ill)
    );

    decode_issue_unit #(.NUM_SLOTS(4), .MEM_PORTS(2)) dut_b (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_slot_valid(b_in_sv), .in_instr(b_in_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_slot_valid(b_out_sv),
        .out_instr(b_out_instr), .out_ctrl(b_out_ctrl), .out_illegal(b_out_ill)
    );

    function automatic logic [31:0] rt_(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] it_(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Reference decoder: returns {illegal, control word} built field by field.
    function automatic logic [16:0] ref_dec(input logic [31:0] w);
        logic [5:0] op, fn;
        logic [1:0] regdst, m2r;
        logic br, bne, mrd, mwr, rwr, asrc, jmp, pcs, ill;
        logic [3:0] alu;
        op = w[31:26]; fn = w[5:0];
        regdst = 0; m2r = 0; br = 0; bne = 0; mrd = 0; mwr = 0; rwr = 0;
        asrc = 0; jmp = 0; pcs = 0; ill = 0; alu = 0;
        if (op == 6'h00) begin
            regdst = 2'b01; rwr = 1;
            case (fn)
                6'h20: alu = 0;  6'h22: alu = 1;  6'h24: alu = 2;  6'h25: alu = 3;
                6'h2A: alu = 4;  6'h14: alu = 5;  6'h27: alu = 6;  6'h15: alu = 7;
                6'h00: alu = 8;  6'h02: alu = 9;
                6'h08: begin pcs = 1; rwr = 0; end
                default: begin ill = 1; rwr = 0; end
            endcase
        end else if (op inside {6'h08, 6'h0C, 6'h0D, 6'h16, 6'h0A}) begin
            asrc = 1; rwr = 1;
            alu = (op == 6'h0C) ? 4'd2 : (op == 6'h0D) ? 4'd3 : (op == 6'h16) ? 4'd7 : (op == 6'h0A) ? 4'd4 : 4'd0;
        end else if (op == 6'h23) begin
            mrd = 1; m2r = 2'b01; asrc = 1; rwr = 1;
        end else if (op == 6'h2B) begin
            mwr = 1; asrc = 1;
        end else if (op == 6'h04 || op == 6'h05) begin
            br = 1; alu = 1; bne = (op == 6'h05);
        end else if (op == 6'h02) begin
            jmp = 1; pcs = 1;
        end else if (op == 6'h03) begin
            jmp = 1; pcs = 1; rwr = 1; regdst = 2'b10; m2r = 2'b10;
        end else begin
            ill = 1;
        end
        return {ill, regdst, br, bne, mrd, m2r, mwr, rwr, asrc, jmp, pcs, alu};
    endfunction

    function automatic logic [4:0] ref_dst(input logic [31:0] w);
        logic [16:0] c;
        c = ref_dec(w);
        if (!c[7]) return 5'd0;
        case (c[15:14])
            2'b01:   return w[15:11];
            2'b10:   return 5'd31;
            default: return w[20:16];
        endcase
    endfunction

    // Next issue group for the given pending mask, by pairwise comparison against earlier members.
    function automatic logic [3:0] ref_group(input logic [127:0] ins, input logic [3:0] pend, input int ns, input int mp);
        int members[$];
        logic [3:0] g;
        logic [31:0] w, e;
        logic [16:0] c, ce;
        logic stop, rd_rt;
        int nmem;
        g = '0;
        for (int i = 0; i < ns; i++) begin
            if (pend[i]) begin
                w = ins[32*i +: 32];
                c = ref_dec(w);
                rd_rt = (w[31:26] == 6'h00) || (w[31:26] == 6'h2B) || (w[31:26] == 6'h04) || (w[31:26] == 6'h05);
                stop = 0; nmem = 0;
                foreach (members[k]) begin
                    e = ins[32*members[k] +: 32];
                    ce = ref_dec(e);
                    if (ce[13] || ce[5] || ce[4]) stop = 1;
                    if (ce[11] || ce[8]) nmem++;
                    if (ref_dst(e) != 5'd0) begin
                        if (ref_dst(e) == w[25:21]) stop = 1;
                        if (rd_rt && ref_dst(e) == w[20:16]) stop = 1;
                        if (ref_dst(e) == ref_dst(w)) stop = 1;
                    end
                end
                if ((c[11] || c[8]) && nmem >= mp) stop = 1;
                if (stop) break;
                members.push_back(i);
                g[i] = 1'b1;
            end
        end
        return g;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0] rs, rt, rd;
        int k;
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3)); rd = 5'($urandom_range(0, 3));
        k = $urandom_range(0, 23);
        case (k)
            0: return rt_(rs, rt, rd, 6'h20);   1: return rt_(rs, rt, rd, 6'h22);
            2: return rt_(rs, rt, rd, 6'h24);   3: return rt_(rs, rt, rd, 6'h25);
            4: return rt_(rs, rt, rd, 6'h2A);   5: return rt_(rs, rt, rd, 6'h14);
            6: return rt_(rs, rt, rd, 6'h27);   7: return rt_(rs, rt, rd, 6'h15);
            8: return rt_(rs, rt, rd, 6'h00);   9: return rt_(rs, rt, rd, 6'h02);
            10: return rt_(rs, rt, rd, 6'h08);  11: return rt_(rs, rt, rd, 6'h3F);
            12: return it_(6'h08, rs, rt, 16'd5); 13: return it_(6'h0C, rs, rt, 16'd1);
            14: return it_(6'h0D, rs, rt, 16'd2); 15: return it_(6'h16, rs, rt, 16'd3);
            16: return it_(6'h0A, rs, rt, 16'd4); 17: return it_(6'h23, rs, rt, 16'd8);
            18: return it_(6'h2B, rs, rt, 16'd8); 19: return it_(6'h04, rs, rt, 16'd2);
            20: return it_(6'h05, rs, rt, 16'd2); 21: return it_(6'h02, rs, rt, 16'h10);
            22: return it_(6'h03, rs, rt, 16'h10);
            default: return {6'($urandom_range(0, 63)), rs, rt, 16'($urandom)};
        endcase
    endfunction

    task automatic accept_a(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] sv);
        int n;
        a_in_instr = {i1, i0}; a_in_sv = sv; a_in_valid = 1'b1; n = 0;
        #1;
        while (!a_in_ready && n < 20) begin @(negedge clk); #1; n++; end
        vectors++;
        if (a_in_ready !== 1'b1) begin miscompares++; $display("FAIL accept_a_timeout in_ready=%b want 1", a_in_ready); end
        @(negedge clk);
        a_in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0;
        a_in_valid = 0; a_in_sv = 0; a_in_instr = 0; a_out_ready = 1;
        b_in_valid = 0; b_in_sv = 0; b_in_instr = 0; b_out_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if (a_out_valid !== 0 || a_out_sv !== 0 || a_out_ctrl !== 0 || a_out_instr !== 0 || a_out_ill !== 0) begin
            miscompares++; $display("FAIL reset_outputs got v=%b sv=%b ctrl=%h want all 0", a_out_valid, a_out_sv, a_out_ctrl);
        end
        vectors++;
        if (a_in_ready !== 0 || b_in_ready !== 0) begin
            miscompares++; $display("FAIL reset_in_ready got a=%b b=%b want 0", a_in_ready, b_in_ready);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (a_in_ready !== 1 || b_in_ready !== 1) begin
            miscompares++; $display("FAIL release_in_ready got a=%b b=%b want 1", a_in_ready, b_in_ready);
        end
    endtask

    task automatic test_single_group();
        logic [31:0] i0, i1;
        i0 = rt_(5'd1, 5'd2, 5'd3, 6'h20); i1 = rt_(5'd5, 5'd6, 5'd4, 6'h22);
        a_out_ready = 1;
        accept_a(i0, i1, 2'b11);
        vectors++;
        if (a_out_valid !== 0) begin miscompares++; $display("FAIL single_latency got %b want 0", a_out_valid); end
        @(negedge clk); #1;
        vectors++;
        if (a_out_valid !== 1 || a_out_sv !== 2'b11) begin
            miscompares++; $display("FAIL single_group got v=%b sv=%b want 1/11", a_out_valid, a_out_sv);
        end
        vectors++;
        if (a_out_ctrl !== 32'h4081_4080 || a_out_ill !== 2'b00 || a_out_instr !== {i1, i0}) begin
            miscompares++; $display("FAIL single_ctrl got %h ill=%b want 40814080 ill=00", a_out_ctrl, a_out_ill);
        end
        @(negedge clk); #1;
        vectors++;
        if (a_out_valid !== 0) begin miscompares++; $display("FAIL single_drain got %b want 0", a_out_valid); end
    endtask

    task automatic test_raw_split();
        a_out_ready = 1;
        accept_a(it_(6'h08, 5'd0, 5'd1, 16'd5), rt_(5'd1, 5'd1, 5'd2, 6'h20), 2'b11);
        vectors++;
        if (a_in_ready !== 0 || a_out_valid !== 0) begin
            miscompares++; $display("FAIL raw_first_cycle got rdy=%b v=%b want 0/0", a_in_ready, a_out_valid);
        end
        @(negedge clk); #1;
        vectors++;
        if (a_out_valid !== 1 || a_out_sv !== 2'b01 || a_out_ctrl !== 32'h0000_00C0 || a_in_ready !== 1) begin
            miscompares++; $display("FAIL raw_group0 got sv=%b ctrl=%h rdy=%b want 01/000000c0/1", a_out_sv, a_out_ctrl, a_in_ready);
        end
        @(negedge clk); #1;
        vectors++;
        if (a_out_valid !== 1 || a_out_sv !== 2'b10 || a_out_ctrl !== 32'h4080_0000) begin
            miscompares++; $display("FAIL raw_group1 got sv=%b ctrl=%h want 10/40800000", a_out_sv, a_out_ctrl);
        end
        @(negedge clk); #1;
        vectors++;
        if (a_out_valid !== 0) begin miscompares++; $display("FAIL raw_drain got %b want 0", a_out_valid); end
    endtask

    task automatic test_mem_ports();
        logic [31:0] lw, sw;
        lw = it_(6'h23, 5'd2, 5'd1, 16'd0); sw = it_(6'h2B, 5'd4, 5'd3, 16'd4);
        a_out_ready = 1;
        accept_a(lw, sw, 2'b11);
        @(negedge clk); #1;
        vectors++;
        if (a_out_sv !== 2'b01 || a_out_ctrl !== 32'h0000_0AC0) begin
            miscompares++; $display("FAIL mem1_group0 got sv=%b ctrl=%h want 01/00000ac0", a_out_sv, a_out_ctrl);
        end
        @(negedge clk); #1;
        vectors++;
        if (a_out_sv !== 2'b10 || a_out_ctrl !== 32'h0140_0000) begin
            miscompares++; $display("FAIL mem1_group1 got sv=%b ctrl=%h want 10/01400000", a_out_sv, a_out_ctrl);
        end
        b_out_ready = 1; b_in_instr = {64'h0, sw, lw}; b_in_sv = 4'b0011; b_in_valid = 1;
        #1;
        vectors++;
        if (b_in_ready !== 1) begin miscompares++; $display("FAIL mem2_ready got %b want 1", b_in_ready); end
        @(negedge clk); b_in_valid = 0;
        @(negedge clk); #1;
        vectors++;
        if (b_out_valid !== 1 || b_out_sv !== 4'b0011 || b_out_ctrl !== 64'h0000_0000_0140_0AC0) begin
            miscompares++; $display("FAIL mem2_group got v=%b sv=%b ctrl=%h want 1/0011/0000000001400ac0", b_out_valid, b_out_sv, b_out_ctrl);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_control_ops();
        a_out_ready = 1;
        accept_a(it_(6'h04, 5'd1, 5'd2, 16'd3), rt_(5'd4, 5'd5, 5'd3, 6'h20), 2'b11);
        @(negedge clk); #1;
        vectors++;
        if (a_out_sv !== 2'b01 || a_out_ctrl !== 32'h0000_2001) begin
            miscompares++; $display("FAIL beq_group0 got sv=%b ctrl=%h want 01/00002001", a_out_sv, a_out_ctrl);
        end
        @(negedge clk); #1;
        vectors++;
        if (a_out_sv !== 2'b10 || a_out_ctrl !== 32'h4080_0000) begin
            miscompares++; $display("FAIL beq_group1 got sv=%b ctrl=%h want 10/40800000", a_out_sv, a_out_ctrl);
        end
        accept_a(it_(6'h05, 5'd1, 5'd2, 16'd3), rt_(5'd4, 5'd5, 5'd3, 6'h20), 2'b11);
        @(negedge clk); #1;
        vectors++;
        if (a_out_sv !== 2'b01 || a_out_ctrl !== 32'h0000_3001) begin
            miscompares++; $display("FAIL bne_ctrl got sv=%b ctrl=%h want 01/00003001", a_out_sv, a_out_ctrl);
        end
        @(negedge clk); #1;
        accept_a({6'h03, 26'd100}, {6'h3F, 26'd0}, 2'b11);
        @(negedge clk); #1;
        vectors++;
        if (a_out_sv !== 2'b01 || a_out_ctrl !== 32'h0000_84B0 || a_out_ill !== 2'b00) begin
            miscompares++; $display("FAIL jal_ctrl got sv=%b ctrl=%h ill=%b want 01/000084b0/00", a_out_sv, a_out_ctrl, a_out_ill);
        end
        @(negedge clk); #1;
        vectors++;
        if (a_out_sv !== 2'b10 || a_out_ctrl !== 32'h0 || a_out_ill !== 2'b10) begin
            miscompares++; $display("FAIL illegal_op got sv=%b ctrl=%h ill=%b want 10/00000000/10", a_out_sv, a_out_ctrl, a_out_ill);
        end
        @(negedge clk); #1;
    endtask

    task automatic test_stall_flush();
        logic [31:0] lw, sw;
        lw = it_(6'h23, 5'd2, 5'd1, 16'd0); sw = it_(6'h2B, 5'd4, 5'd3, 16'd4);
        a_out_ready = 0;
        accept_a(lw, sw, 2'b11);
        @(negedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            vectors++;
            if (a_out_valid !== 1 || a_out_sv !== 2'b01 || a_out_ctrl !== 32'h0000_0AC0 || a_in_ready !== 0) begin
                miscompares++; $display("FAIL stall_hold got v=%b sv=%b ctrl=%h rdy=%b want 1/01/00000ac0/0", a_out_valid, a_out_sv, a_out_ctrl, a_in_ready);
            end
        end
        a_out_ready = 1;
        @(negedge clk); #1;
        vectors++;
        if (a_out_valid !== 1 || a_out_sv !== 2'b10 || a_out_ctrl !== 32'h0140_0000) begin
            miscompares++; $display("FAIL stall_resume got sv=%b ctrl=%h want 10/01400000", a_out_sv, a_out_ctrl);
        end
        @(negedge clk); #1;
        accept_a(lw, sw, 2'b11);
        @(negedge clk); #1;
        flush = 1; #1;
        vectors++;
        if (a_in_ready !== 0) begin miscompares++; $display("FAIL flush_in_ready got %b want 0", a_in_ready); end
        @(negedge clk); flush = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            vectors++;
            if (a_out_valid !== 0) begin miscompares++; $display("FAIL flush_squash got %b want 0", a_out_valid); end
            @(negedge clk);
        end
        #1;
    endtask

    task automatic test_reset_mid_issue();
        a_out_ready = 0;
        accept_a(it_(6'h23, 5'd2, 5'd1, 16'd0), it_(6'h2B, 5'd4, 5'd3, 16'd4), 2'b11);
        @(negedge clk); #2;
        rst = 0; #1;
        vectors++;
        if (a_out_valid !== 0 || a_out_sv !== 0 || a_out_ctrl !== 0 || a_out_instr !== 0 || a_out_ill !== 0 || a_in_ready !== 0) begin
            miscompares++; $display("FAIL async_reset got v=%b sv=%b ctrl=%h rdy=%b want all 0", a_out_valid, a_out_sv, a_out_ctrl, a_in_ready);
        end
        @(negedge clk); rst = 1; a_out_ready = 1;
        @(negedge clk); #1;
        vectors++;
        if (a_in_ready !== 1 || a_out_valid !== 0) begin
            miscompares++; $display("FAIL post_reset got rdy=%b v=%b want 1/0", a_in_ready, a_out_valid);
        end
        @(negedge clk); #1;
        vectors++;
        if (a_out_valid !== 0) begin miscompares++; $display("FAIL post_reset_no_group got %b want 0", a_out_valid); end
    endtask

    task automatic test_random_b();
        logic sent;
        logic [3:0] pend, g, ill;
        logic [63:0] ctrl;
        logic [16:0] d;
        sent = 0; b_in_valid = 0;
        for (int cyc = 0; cyc < 700; cyc++) begin
            @(negedge clk);
            if (sent) begin b_in_valid = 0; sent = 0; end
            if (!b_in_valid && cyc < 550 && $urandom_range(0, 2) != 0) begin
                for (int s = 0; s < 4; s++) b_in_instr[32*s +: 32] = rand_instr();
                b_in_sv = 4'($urandom_range(0, 15));
                b_in_valid = 1;
            end
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (b_out_valid && b_out_ready) begin
                vectors++;
                if (q_sv.size() == 0) begin
                    miscompares++; $display("FAIL rand_extra_group got sv=%b want none", b_out_sv);
                end else begin
                    if (b_out_sv !== q_sv[0] || b_out_ctrl !== q_ctrl[0] || b_out_ill !== q_ill[0] || b_out_instr !== q_instr[0]) begin
                        miscompares++;
                        $display("FAIL rand_group got sv=%b ctrl=%h ill=%b want sv=%b ctrl=%h ill=%b",
                                 b_out_sv, b_out_ctrl, b_out_ill, q_sv[0], q_ctrl[0], q_ill[0]);
                    end
                    void'(q_sv.pop_front()); void'(q_ctrl.pop_front());
                    void'(q_ill.pop_front()); void'(q_instr.pop_front());
                end
            end
            if (b_in_valid && b_in_ready) begin
                sent = 1;
                pend = b_in_sv;
                while (pend != 0) begin
                    g = ref_group(b_in_instr, pend, 4, 2);
                    if (g == 0) break;
                    ctrl = '0; ill = '0;
                    for (int s = 0; s < 4; s++) begin
                        d = ref_dec(b_in_instr[32*s +: 32]);
                        if (g[s]) begin ctrl[16*s +: 16] = d[15:0]; ill[s] = d[16]; end
                    end
                    q_sv.push_back(g); q_ctrl.push_back(ctrl); q_ill.push_back(ill); q_instr.push_back(b_in_instr);
                    pend = pend & ~g;
                end
            end
        end
        vectors++;
        if (q_sv.size() != 0) begin miscompares++; $display("FAIL rand_lost_groups got %0d pending want 0", q_sv.size()); end
    endtask

    initial begin
        test_reset();
        test_single_group();
        test_raw_split();
        test_mem_ports();
        test_control_ops();
        test_stall_flush();
        test_reset_mid_issue();
        test_random_b();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
